// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage access controller placed in front of a 64-word data memory.
// Accepts a single load or store from the EXE/MEM pipeline register and
// converts the byte address into a word index. It also checks that the
// address is aligned and inside the mapped window. An accepted request is
// run as a multi-cycle transaction, and the pipeline is frozen while it runs.
//
// Parameters
//   BASE_ADDR    byte address mapped to memory word 0
//   WAIT_CYCLES  cycles the memory is driven per access (1..15)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   mem_r_en    load request from the pipeline
//   mem_w_en    store request from the pipeline
//   alu_result  byte address (unsigned)
//   st_val      store data
//   mem_result  read data returned by the memory
//   mem_read    memory read enable
//   mem_write   memory write enable (one cycle per store)
//   address     memory word index
//   data        memory write data
//   freeze      pipeline stall
//   rd_data     registered load result
//   ready       one-cycle completion pulse
//   addr_error  one-cycle pulse after a rejected request
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_result,
    input  logic [31:0] st_val,
    input  logic [31:0] mem_result,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  address,
    output logic [31:0] data,
    output logic        freeze,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic        addr_error
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [31:0] ADDR_LO  = BASE_ADDR;
    localparam logic [31:0] ADDR_HI  = BASE_ADDR + 32'd252;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_store_q;

    logic        one_op;
    logic        any_op;
    logic        addr_ok;
    logic        accept;
    logic        reject;
    logic [5:0]  word_idx;
    logic        last_cycle;

    // ----------------------------------------------------------------------
    // Request decode. Only used in IDLE: DONE still shows the request that
    // was just served, so it must not be decoded again there.
    // ----------------------------------------------------------------------
    assign one_op   = mem_r_en ^ mem_w_en;
    assign any_op   = mem_r_en | mem_w_en;
    assign addr_ok  = (alu_result >= ADDR_LO) && (alu_result <= ADDR_HI) &&
                      (alu_result[1:0] == 2'b00);
    assign accept   = (state_q == IDLE) && one_op && addr_ok;
    assign reject   = (state_q == IDLE) && any_op && !(one_op && addr_ok);
    assign word_idx = 6'((alu_result - ADDR_LO) >> 2);

    // Final ACCESS cycle: a store writes in this cycle, and a load captures
    // its data at the closing edge.
    assign last_cycle = (state_q == ACCESS) && (cnt_q == 4'd1);

    // ----------------------------------------------------------------------
    // Next-state and output decode
    // ----------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement, so that no
    //       path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        freeze    = 1'b0;
        ready     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    freeze  = 1'b1;
                end
            end
            ACCESS: begin
                freeze    = 1'b1;
                mem_read  = !is_store_q;
                mem_write = is_store_q && (cnt_q == 4'd1);
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // In IDLE, freeze follows the request inputs combinationally. It is
        // masked here so that freeze stays low while reset is held.
        if (rst) begin
            freeze = 1'b0;
        end
    end

    // ----------------------------------------------------------------------
    // Control state
    // ----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    //       register samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_error <= reject;
        end
    end

    // ----------------------------------------------------------------------
    // Datapath registers: the latched request and the load result
    // ----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address    <= 6'd0;
            data       <= 32'd0;
            is_store_q <= 1'b0;
            rd_data    <= 32'd0;
        end else begin
            if (accept) begin
                address    <= word_idx;
                data       <= st_val;
                is_store_q <= mem_w_en;
            end
            if (last_cycle && !is_store_q) begin
                rd_data <= mem_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Self-checking bench for mem_access_ctrl. The bench owns the 64-word memory
// that the DUT drives. A transaction-level reference model records when a
// request was accepted and how many cycles have passed since. From that
// elapsed count it derives every expected output, and it keeps its own copy
// of the memory contents. The directed sequences follow the test plan and
// include literal expectations. A randomized phase follows, with occasional
// asynchronous reset pulses.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int W    = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] alu_result, st_val, mem_result;
    logic        mem_read, mem_write, freeze, ready, addr_error;
    logic [5:0]  address;
    logic [31:0] data, rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .alu_result (alu_result),
        .st_val     (st_val),
        .mem_result (mem_result),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .data       (data),
        .freeze     (freeze),
        .rd_data    (rd_data),
        .ready      (ready),
        .addr_error (addr_error)
    );

    always #5 clk = ~clk;

    // Environment memory, written by the DUT and read combinationally
    logic [31:0] env_mem [64];
    assign mem_result = env_mem[address];
    always @(posedge clk) begin
        if (mem_write) env_mem[address] <= data;
    end

    // ---------------- reference model ----------------
    bit          m_busy;     // a transaction has been accepted
    int          m_k;        // cycles elapsed since acceptance (ACCESS = 1..W, DONE = W+1)
    bit          m_store;
    logic [5:0]  m_idx;      // last latched word index
    logic [31:0] m_wdata;    // last latched store data
    logic [31:0] m_rd;       // expected rd_data
    bit          m_err;      // expected addr_error
    logic [31:0] ref_mem [64];

    function automatic bit addr_ok(input logic [31:0] a);
        longint unsigned av = a;
        return (av >= BASE) && (av <= BASE + 252) && (av % 4 == 0);
    endfunction

    function automatic bit model_valid();
        return !m_busy && (mem_r_en != mem_w_en) && addr_ok(alu_result);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_store = 0; m_idx = '0; m_wdata = '0;
        m_rd = '0; m_err = 0;
    endtask

    // Advance the model across one rising edge, using the inputs of the cycle
    // that is ending.
    task automatic model_step();
        bit v;
        if (rst) begin
            model_reset();
            return;
        end
        v     = model_valid();
        m_err = !m_busy && (mem_r_en || mem_w_en) && !v;
        if (m_busy) begin
            if (m_k == W) begin
                if (m_store) ref_mem[m_idx] = m_wdata;
                else         m_rd = ref_mem[m_idx];
            end
            if (m_k == W + 1) m_busy = 0;
            else              m_k++;
        end else if (v) begin
            m_busy  = 1;
            m_k     = 1;
            m_store = mem_w_en;
            m_idx   = 6'((alu_result - BASE) / 4);
            m_wdata = st_val;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Compare process: every output, on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit in_access;
                in_access = m_busy && (m_k <= W);
                check("freeze",     freeze,     !rst && (in_access || model_valid()));
                check("mem_read",   mem_read,   in_access && !m_store);
                check("mem_write",  mem_write,  in_access && m_store && (m_k == W));
                check("ready",      ready,      m_busy && (m_k == W + 1));
                check("addr_error", addr_error, m_err);
                check("address",    address,    m_idx);
                check("data",       data,       m_wdata);
                check("rd_data",    rd_data,    m_rd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Wait for the next rising edge, step the model, then apply the inputs
    // for the new cycle.
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
        @(posedge clk);
        model_step();
        #1;
        mem_r_en   = r;
        mem_w_en   = w;
        alu_result = a;
        st_val     = v;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, $urandom, $urandom);
    endtask

    // Assert reset in the middle of the current cycle, then release it after
    // the falling edge.
    task automatic rst_pulse();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_freeze",    freeze,    1'b0);
        check("rst_async_mem_write", mem_write, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel = $urandom_range(0, 99);
        if (sel < 60) return BASE + 4 * $urandom_range(0, 63);
        if (sel < 68) return BASE;
        if (sel < 76) return BASE + 252;
        if (sel < 84) return BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
        if (sel < 88) return BASE - 4;
        if (sel < 92) return BASE + 256;
        return $urandom;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        rst        = 1'b1;
        mem_r_en   = 1'b1;
        mem_w_en   = 1'b0;
        alu_result = BASE;
        st_val     = $urandom;

        // Reset held for two cycles while a valid load request is present
        step(1'b1, 1'b0, BASE + 8, $urandom);
        @(negedge clk);
        check("reset_freeze_low", freeze, 1'b0);
        step(1'b1, $urandom_range(0, 1), $urandom, $urandom);
        @(negedge clk);
        check("reset_rd_data", rd_data, 32'd0);
        #2 rst = 1'b0;
        idle();

        // Store 0xDEADBEEF to 1028
        step(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        @(negedge clk);
        check("st_freeze_c0", freeze, 1'b1);
        idle();
        @(negedge clk);
        check("st_address", address, 6'd1);
        check("st_data", data, 32'hDEADBEEF);
        check("st_no_write_c1", mem_write, 1'b0);
        idle();
        @(negedge clk);
        check("st_write_c2", mem_write, 1'b1);
        idle();
        @(negedge clk);
        check("st_ready_c3", ready, 1'b1);
        check("st_rd_unchanged", rd_data, 32'd0);
        check("st_freeze_c3", freeze, 1'b0);

        // Load it back
        step(1'b1, 1'b0, 32'd1028, $urandom);
        idle();
        @(negedge clk);
        check("ld_read_c1", mem_read, 1'b1);
        idle();
        idle();
        @(negedge clk);
        check("ld_ready_c3", ready, 1'b1);
        check("ld_rd_data", rd_data, 32'hDEADBEEF);

        // Rejected requests
        step(1'b1, 1'b0, 32'd1030, $urandom);
        @(negedge clk);
        check("err_misaligned_no_freeze", freeze, 1'b0);
        idle();
        @(negedge clk);
        check("err_misaligned_pulse", addr_error, 1'b1);
        step(1'b0, 1'b1, 32'd1280, $urandom);
        idle();
        @(negedge clk);
        check("err_range_pulse", addr_error, 1'b1);
        step(1'b1, 1'b1, 32'd1024, $urandom);
        idle();
        @(negedge clk);
        check("err_both_pulse", addr_error, 1'b1);
        idle();
        @(negedge clk);
        check("err_pulse_ends", addr_error, 1'b0);

        // Load held through DONE, then a store to the top word
        repeat (W + 2) step(1'b1, 1'b0, 32'd1028, $urandom);
        step(1'b0, 1'b1, 32'd1276, 32'h0BADF00D);
        @(negedge clk);
        check("held_store_freeze", freeze, 1'b1);
        idle();
        @(negedge clk);
        check("held_store_addr63", address, 6'd63);
        repeat (W + 1) idle();

        // Reset during a store to 1032, then read that word back
        step(1'b0, 1'b1, 32'd1032, 32'h12345678);
        idle();
        rst_pulse();
        repeat (2) idle();
        step(1'b1, 1'b0, 32'd1032, $urandom);
        repeat (W + 1) idle();
        @(negedge clk);
        check("rst_store_ready", ready, 1'b1);
        check("rst_store_readback", rd_data, 32'd0);
        idle();

        // Randomized traffic with held requests and occasional resets
        for (int n = 0; n < 500; n++) begin
            int          sel  = $urandom_range(0, 99);
            int          hold = $urandom_range(1, 3);
            logic        r = 1'b0;
            logic        w = 1'b0;
            logic [31:0] a = rand_addr();
            logic [31:0] v = $urandom;
            if (sel >= 35 && sel < 62)      r = 1'b1;
            else if (sel >= 62 && sel < 90) w = 1'b1;
            else if (sel >= 90) begin
                r = 1'b1;
                w = 1'b1;
            end
            for (int h = 0; h < hold; h++) step(r, w, a, v);
            if ($urandom_range(0, 99) == 0) rst_pulse();
        end
        repeat (W + 3) idle();
        @(negedge clk);

        for (int i = 0; i < 64; i++) begin
            check($sformatf("mem_word_%0d", i), env_mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
